neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Sequential multiply-accumulate neuron core.
- Accepts N_INPUTS signed input/weight pairs over a valid/ready stream and forms sum(x*w) + bias.
- Saturates the result to a 17-bit signed value and presents it on a valid/ready output.
- Sits directly upstream of the ReLU activation stage, which consumes the 17-bit signed pre-activation sum.

Parameters:
- N_INPUTS, 4, number of input/weight beats per neuron evaluation (>=1).
- DATA_W, 8, width of signed input and weight samples.
- BIAS_W, 16, width of signed bias.
- ACC_W, 24, internal signed accumulator width; must be >= 2*DATA_W + clog2(N_INPUTS) + 2 and > BIAS_W.
- OUT_W, 17, width of signed saturated output.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_x/in_w beat valid.
- in_ready  output  1  core accepts a beat this cycle.
- in_x  input  DATA_W  signed neuron input sample.
- in_w  input  DATA_W  signed weight for in_x.
- bias  input  BIAS_W  signed bias; sampled on the final (N_INPUTS-th) accepted beat.
- out_valid  output  1  out_sum valid.
- out_ready  input  1  downstream accepts out_sum.
- out_sum  output  OUT_W  signed saturated sum(x*w)+bias.
- out_sat  output  1  saturation occurred for the current out_sum.

Behaviour:
- State machine: S_ACC (accumulating) and S_OUT (result held).
- Reset (rst_n low at posedge clk): state=S_ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_sat=0. in_ready is 1 from the first cycle after reset.
- in_ready = (state==S_ACC). It is combinational from state only and never depends on in_valid.
- A beat is accepted when in_valid && in_ready at posedge clk. Cycles with in_valid low change nothing.
- Product: signed DATA_W x DATA_W -> 2*DATA_W, sign-extended to ACC_W.
- Non-final beat (cnt < N_INPUTS-1): acc <= acc + prod; cnt <= cnt+1.
- Final beat (cnt == N_INPUTS-1):
  - total = acc + prod + sext(bias), computed at ACC_W.
  - total > 2^(OUT_W-1)-1 gives out_sum = 65535 and out_sat = 1.
  - total < -2^(OUT_W-1) gives out_sum = -65536 and out_sat = 1.
  - Otherwise out_sum = total[OUT_W-1:0] and out_sat = 0.
  - out_valid <= 1; state <= S_OUT; acc <= 0; cnt <= 0.
- Latency: out_valid rises on the clock edge that accepts the final beat, so it is visible the cycle after the final beat is presented.
- S_OUT:
  - out_sum, out_sat and out_valid are held stable until out_valid && out_ready.
  - in_ready = 0 and in_x/in_w/bias are ignored.
- On output handshake: out_valid <= 0, state <= S_ACC. out_sum and out_sat retain their last values.
  - A new beat presented in the cycle after the handshake is accepted.
  - No beat is accepted in the handshake cycle itself, because in_ready is still 0.
- N_INPUTS==1: every accepted beat is the final beat.
- The accumulator must never wrap internally given the ACC_W constraint. Saturation applies only at the output.
- Reset mid-operation: partial accumulation is discarded and held output is dropped (out_valid=0). The next accepted beat is treated as beat 0.
- No X propagation: acc, cnt, state and all outputs are reset explicitly.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_sum=0, out_sat=0 throughout; in_ready=1 on the first cycle after release.
- Nominal: N_INPUTS=4, x={1,2,3,4}, w={5,6,7,8}, bias=10, back-to-back beats, out_ready=1 -> out_sum=80, out_sat=0; out_valid high exactly 1 cycle after the 4th beat.
- Positive saturation: x=-128, w=-128 for 4 beats, bias=100 (total 65636) -> out_sum=65535, out_sat=1.
- Negative saturation: x=127, w=-128 for 4 beats, bias=-1000 (total -66024) -> out_sum=-65536, out_sat=1.
- Stalls and backpressure:
  - Nominal vector with in_valid low for 2 cycles between beats 2 and 3 -> out_sum=80.
  - Then hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_sum stable, in_ready=0.
  - Release out_ready -> a following vector x={1,1,1,1}, w={1,1,1,1}, bias=0 gives out_sum=4, proving acc was cleared.
- Reset mid-vector: accept 2 beats of x=10, w=10, pulse rst_n=0 for 1 cycle, then send x={1,2,3,4}, w={5,6,7,8}, bias=10 -> out_sum=80, with no output produced from the aborted vector.

Source files
------------

// File: rtl/neuron_mac.sv
//------------------------------------------------------------------------------
// neuron_mac : sequential signed multiply-accumulate neuron core with bias
//              and saturated 17-bit pre-activation output.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int BIAS_W   = 16,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic [BIAS_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sum,
    output logic              out_sat
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_sum_q, out_sum_d;
    logic                     out_sat_q, out_sat_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    total;

    assign prod     = $signed(in_x) * $signed(in_w);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    assign total    = acc_q + prod_ext + bias_ext;

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    if (cnt_q == LAST_CNT) begin
                        // Saturation happens only here; the wide accumulator never wraps.
                        if (total > SAT_MAX) begin
                            out_sum_d = SAT_MAX[OUT_W-1:0];
                            out_sat_d = 1'b1;
                        end else if (total < SAT_MIN) begin
                            out_sum_d = SAT_MIN[OUT_W-1:0];
                            out_sat_d = 1'b1;
                        end else begin
                            out_sum_d = total[OUT_W-1:0];
                            out_sat_d = 1'b0;
                        end
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end else begin
                        acc_d = acc_q + prod_ext;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac.sv
//------------------------------------------------------------------------------
// tb_neuron_mac : directed-vector scoreboard bench for neuron_mac.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_w;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    typedef int vec_t [4];
    typedef struct packed {
        logic [16:0] sum;
        logic        sat;
    } exp_t;
    exp_t sb [$];

    neuron_mac #(
        .N_INPUTS(4),
        .DATA_W  (8),
        .BIAS_W  (16),
        .ACC_W   (24),
        .OUT_W   (17)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_w     (in_w),
        .bias     (bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum 0x%0h with no expected result", out_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_sat", 32'(out_sat), 32'(e.sat));
            end
        end
    end

    // Drives one 4-beat vector; non-final beats carry junk bias so sampling is exercised.
    task automatic send_vec(input vec_t xs, input vec_t ws, input int b, input bit gap,
                            input logic [16:0] esum, input logic esat);
        for (int i = 0; i < 4; i++) begin
            if (gap && i == 2) begin
                in_valid = 1'b0;
                in_x     = 8'h55;
                in_w     = 8'h55;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_x     = 8'(xs[i]);
            in_w     = 8'(ws[i]);
            bias     = (i == 3) ? 16'(b) : 16'h7FFF;
            if (i == 0) check("in_ready_beat0", 32'(in_ready), 32'd1);
            if (i == 3) begin
                check("out_valid_before_final", 32'(out_valid), 32'd0);
                sb.push_back('{sum: esum, sat: esat});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("out_valid_after_final", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t nx, nw, sx, sw, px, pw, ones, tens;
        nx   = '{1, 2, 3, 4};
        nw   = '{5, 6, 7, 8};
        sx   = '{-128, -128, -128, -128};
        sw   = '{-128, -128, -128, -128};
        px   = '{127, 127, 127, 127};
        pw   = '{-128, -128, -128, -128};
        ones = '{1, 1, 1, 1};
        tens = '{10, 10, 10, 10};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_x      = 8'd3;
        in_w      = 8'd3;
        bias      = 16'd0;
        out_ready = 1'b1;

        // Reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_sum", 32'(out_sum), 32'd0);
            check("rst_out_sat", 32'(out_sat), 32'd0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        check("out_valid_after_reset", 32'(out_valid), 32'd0);

        // Nominal: 5+12+21+32+10 = 80
        send_vec(nx, nw, 10, 1'b0, 17'd80, 1'b0);
        drain();

        // Positive saturation: 4*16384+100 = 65636
        send_vec(sx, sw, 100, 1'b0, 17'h0FFFF, 1'b1);
        drain();

        // Negative saturation: 4*(-16256)-1000 = -66024
        send_vec(px, pw, -1000, 1'b0, 17'h10000, 1'b1);
        drain();

        // Stall between beats 2 and 3, then backpressure
        out_ready = 1'b0;
        send_vec(nx, nw, 10, 1'b1, 17'd80, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 8'd100;
            in_w     = 8'd100;
            @(posedge clk);
            #1;
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_sum", 32'(out_sum), 32'd80);
        end
        // Handshake cycle: in_valid stays high with junk that must not be accepted
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("sum_retained_after_hs", 32'(out_sum), 32'd80);
        send_vec(ones, ones, 0, 1'b0, 17'd4, 1'b0);
        drain();

        // Reset mid-vector: two beats of 10*10 then abort
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = 8'(tens[i]);
            in_w     = 8'(tens[i]);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        send_vec(nx, nw, 10, 1'b0, 17'd80, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
